// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parametrised CPU register file: one write port, two registered read ports,
// write-first forwarding and a hardware clear sequencer that zeroes the array
// one entry per cycle while BUSY is high.
//
// Ports:
//   CLOCK        in   1           single clock, all state updates on posedge
//   RESET        in   1           synchronous active-low reset
//   IN           in   DATA_WIDTH  write data
//   INADDRESS    in   ADDR_WIDTH  write register number
//   WRITE        in   1           write enable
//   OUT1ADDRESS  in   ADDR_WIDTH  read port 1 register number
//   OUT2ADDRESS  in   ADDR_WIDTH  read port 2 register number
//   OUT1         out  DATA_WIDTH  registered read data, port 1
//   OUT2         out  DATA_WIDTH  registered read data, port 2
//   CLEAR        in   1           request a full-array clear sweep
//   BUSY         out  1           high while the clear sweep is running
//   WR_REJECT    out  1           one-cycle pulse per WRITE dropped while BUSY
//
// Optional build macro:
//   REG_FILE_ZERO_REG_EN  - register 0 is hard-wired to zero; writes to it
//                           are silently discarded.
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  WR_REJECT
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
    logic [DATA_WIDTH-1:0]   out1_q, out1_d;
    logic [DATA_WIDTH-1:0]   out2_q, out2_d;
    logic                    wr_reject_q, wr_reject_d;
    logic                    wr_accept;

    // A write only lands while idle; in zero-register builds writes to
    // address 0 are dropped here so they never reach the array or the
    // forwarding path.
    always_comb begin
`ifdef REG_FILE_ZERO_REG_EN
        wr_accept = (state_q == IDLE) && WRITE && (INADDRESS != '0);
`else
        wr_accept = (state_q == IDLE) && WRITE;
`endif
    end

    // Next-state logic. The read data is taken from the *next* array image,
    // which gives write-first forwarding and sweep-clear forwarding for free.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        wr_reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_accept) begin
                    regs_d[INADDRESS] = IN;
                end
                if (CLEAR) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                wr_reject_d   = WRITE;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef REG_FILE_ZERO_REG_EN
        regs_d[0] = '0;
`endif

        out1_d = regs_d[OUT1ADDRESS];
        out2_d = regs_d[OUT2ADDRESS];
    end

    // State registers; reset aborts any sweep in progress.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            wr_reject_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            wr_reject_q <= wr_reject_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign OUT1      = out1_q;
    assign OUT2      = out2_q;
    assign BUSY      = (state_q == SWEEP);
    assign WR_REJECT = wr_reject_q;

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Directed bench for reg_file_param (DATA_WIDTH=8, ADDR_WIDTH=3). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so every step is "set inputs, take one edge, look".
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [2:0] waddr;
    logic       wr;
    logic [2:0] raddr1;
    logic [2:0] raddr2;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       clr;
    logic       busy;
    logic       wr_reject;

    int compared;
    int mismatched;

    reg_file_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .CLOCK      (clk),
        .RESET      (rst_n),
        .IN         (din),
        .INADDRESS  (waddr),
        .WRITE      (wr),
        .OUT1ADDRESS(raddr1),
        .OUT2ADDRESS(raddr2),
        .OUT1       (out1),
        .OUT2       (out2),
        .CLEAR      (clr),
        .BUSY       (busy),
        .WR_REJECT  (wr_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs, take one rising edge, settle just after it.
    task automatic applyStimulus(input logic w, input logic [2:0] wa,
                                 input logic [7:0] d, input logic [2:0] a1,
                                 input logic [2:0] a2, input logic c);
        wr     = w;
        waddr  = wa;
        din    = d;
        raddr1 = a1;
        raddr2 = a2;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [7:0] r0_expect;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        wr = 1'b0; waddr = '0; din = '0; raddr1 = '0; raddr2 = '0; clr = 1'b0;

        // ---- Reset then readback ----
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_out1", out1, 8'h00);
        checkOutput("reset_out2", out2, 8'h00);
        checkOutput("reset_busy", {7'b0, busy}, 8'h00);
        checkOutput("reset_wr_reject", {7'b0, wr_reject}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
            checkOutput($sformatf("reset_read1_r%0d", i), out1, 8'h00);
            checkOutput($sformatf("reset_read2_r%0d", 7 - i), out2, 8'h00);
        end

        // ---- Write/read latency ----
        applyStimulus(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0);
        checkOutput("latency_r3", out1, 8'hA5);

        // ---- Forwarding on both ports ----
        applyStimulus(1'b1, 3'd5, 8'h12, 3'd0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 1'b0);
        checkOutput("fwd_out1", out1, 8'h3C);
        checkOutput("fwd_out2", out2, 8'h3C);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 1'b0);
        checkOutput("fwd_stored_r5", out1, 8'h3C);
        checkOutput("fwd_r3_kept", out2, 8'hA5);

        // ---- Clear sweep with a blocked write ----
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'((i + 1) * 17), 3'd0, 3'd0, 1'b0);
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd6, 3'd1, 1'b0);
        checkOutput("fill_r6", out1, 8'h77);
        checkOutput("fill_r1", out2, 8'h22);
        // E0
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b1);
        checkOutput("sweep_busy_e0", {7'b0, busy}, 8'h01);
        // E1
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b0);
        checkOutput("sweep_rej_e1", {7'b0, wr_reject}, 8'h00);
        // E2 with a write that must be dropped
        applyStimulus(1'b1, 3'd7, 8'hFF, 3'd7, 3'd6, 1'b0);
        checkOutput("sweep_rej_e2", {7'b0, wr_reject}, 8'h01);
        checkOutput("sweep_busy_e2", {7'b0, busy}, 8'h01);
        // E3
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b0);
        checkOutput("sweep_rej_e3", {7'b0, wr_reject}, 8'h00);
        // E4: CLEAR during the sweep is ignored
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b1);
        // E5, E6
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b0);
        checkOutput("sweep_e6_r7", out1, 8'h88);
        checkOutput("sweep_e6_r6", out2, 8'h77);
        // E7 clears entry 6
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b0);
        checkOutput("sweep_e7_r7", out1, 8'h88);
        checkOutput("sweep_e7_r6", out2, 8'h00);
        checkOutput("sweep_busy_e7", {7'b0, busy}, 8'h01);
        // E8 clears entry 7 and ends the sweep
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b0);
        checkOutput("sweep_e8_r7", out1, 8'h00);
        checkOutput("sweep_busy_e8", {7'b0, busy}, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        checkOutput("sweep_no_restart", {7'b0, busy}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
            checkOutput($sformatf("cleared1_r%0d", i), out1, 8'h00);
            checkOutput($sformatf("cleared2_r%0d", 7 - i), out2, 8'h00);
        end

        // ---- Reset mid-sweep ----
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'h77, 3'd0, 3'd0, 1'b0);
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 1'b0);
        checkOutput("midsweep_pre_busy", {7'b0, busy}, 8'h01);
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 1'b0);
        rst_n = 1'b1;
        checkOutput("midsweep_busy", {7'b0, busy}, 8'h00);
        checkOutput("midsweep_out1", out1, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 1'b0);
        checkOutput("midsweep_r7", out1, 8'h00);
        checkOutput("midsweep_r5", out2, 8'h00);
        // CLEAR together with a write on E0: the write is accepted
        applyStimulus(1'b1, 3'd2, 8'h09, 3'd2, 3'd0, 1'b1);
        checkOutput("e0_write_fwd", out1, 8'h09);
        checkOutput("e0_write_no_reject", {7'b0, wr_reject}, 8'h00);
        checkOutput("e0_busy", {7'b0, busy}, 8'h01);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 1'b0);
        end
        checkOutput("e7_busy", {7'b0, busy}, 8'h01);
        checkOutput("e7_r2", out1, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 1'b0);
        checkOutput("e8_busy", {7'b0, busy}, 8'h00);
        checkOutput("e8_r2", out1, 8'h00);

        // ---- Register 0 behaviour ----
`ifdef REG_FILE_ZERO_REG_EN
        r0_expect = 8'h00;
`else
        r0_expect = 8'hEE;
`endif
        applyStimulus(1'b1, 3'd0, 8'hEE, 3'd0, 3'd0, 1'b0);
        checkOutput("r0_write_fwd", out1, r0_expect);
        checkOutput("r0_write_no_reject", {7'b0, wr_reject}, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        checkOutput("r0_stored", out1, r0_expect);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 8x8 CPU register file.
- Provides one write port and two registered read ports, with configurable data width and depth.
- Adds write-first forwarding, and a hardware clear sequencer that zeroes the array one entry per cycle while reporting BUSY.
- Sits in the CPU datapath between decode (addresses), ALU/memory writeback (IN) and the ALU operand inputs (OUT1/OUT2).

Parameters:
- DATA_WIDTH, 8, width of each register and of IN/OUT1/OUT2.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH registers.

Ports:
- CLOCK  input  1  single clock; all state updates on posedge.
- RESET  input  1  synchronous, active-low reset, sampled on posedge CLOCK.
- IN  input  DATA_WIDTH  write data.
- INADDRESS  input  ADDR_WIDTH  write register number.
- WRITE  input  1  write enable.
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 register number.
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 register number.
- OUT1  output  DATA_WIDTH  registered read data, port 1.
- OUT2  output  DATA_WIDTH  registered read data, port 2.
- CLEAR  input  1  request a full-array clear sweep.
- BUSY  output  1  registered; high while the sweep is in progress.
- WR_REJECT  output  1  registered; one-cycle pulse for each WRITE dropped while BUSY.

Behaviour:
- Reset
  - RESET==0 at a posedge zeroes all DEPTH registers, OUT1, OUT2, BUSY and WR_REJECT.
  - It also sets state=IDLE and the sweep counter to 0.
  - Reset has priority over every other input, including an in-progress sweep (the sweep aborts).
- States: IDLE, SWEEP. BUSY==1 exactly when state==SWEEP.
- Write (IDLE)
  - At a posedge with WRITE==1, regs[INADDRESS] <= IN.
  - This write is accepted even on the edge that also samples CLEAR.
- Read
  - At every non-reset posedge, OUTn <= regs[OUTnADDRESS]. Latency is 1 cycle from address to output.
  - Read addresses are honoured in both states.
- Forwarding (write-first)
  - If a write is accepted on the same edge and INADDRESS==OUTnADDRESS, OUTn <= IN.
  - In SWEEP, if the entry being cleared equals OUTnADDRESS, OUTn <= 0.
  - Both ports forward independently, so both can receive IN on the same edge.
- Clear sequencer
  - IDLE with CLEAR==1 at edge E0: state->SWEEP, counter=0, BUSY=1 after E0.
  - Edges E1..E_DEPTH each do regs[counter] <= 0, counter++.
  - At E_DEPTH, which clears entry DEPTH-1: state->IDLE, BUSY=0, counter wraps to 0.
  - BUSY is therefore high for exactly DEPTH cycles.
  - CLEAR sampled during SWEEP is ignored (no restart, no queuing).
  - CLEAR held high continuously starts a new sweep on the first IDLE edge after completion.
- Write during SWEEP
  - The array is not modified by WRITE.
  - WR_REJECT=1 for the cycle after each rejected edge; otherwise WR_REJECT=0.
  - A WRITE with CLEAR on E0 is not rejected.
- No X propagation: all state is initialised by reset. Outputs before the first reset are undefined and need not be checked.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired to zero.
  - Writes to address 0 are discarded; they do not pulse WR_REJECT in IDLE.
  - Reads of address 0 return 0, including when a write to address 0 is forwarded.
  - The sweep still takes DEPTH cycles.
- Undefined: register 0 behaves as a normal register.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3):
- Reset then readback: RESET=0 for one edge, then read all addresses -> OUT1=OUT2=8'h00, BUSY=0, WR_REJECT=0.
- Write/read latency: write 8'hA5 to r3; next cycle set OUT1ADDRESS=3 -> OUT1=8'hA5 one edge after the address is applied.
- Forwarding: WRITE=1, INADDRESS=5, IN=8'h3C, OUT1ADDRESS=OUT2ADDRESS=5 on the same edge -> both outputs 8'h3C after that edge, not the old r5 value.
- Clear sweep with blocked write:
  - Setup: fill r0..r7 with 8'h11..8'h88, then pulse CLEAR.
  - Expected: BUSY high for exactly 8 cycles; all regs read 8'h00 afterwards.
  - Also: a WRITE of 8'hFF to r7 on E2 gives WR_REJECT=1 for one cycle, and r7 stays 8'h00.
- Reset mid-sweep: fill regs with 8'h77, pulse CLEAR, assert RESET=0 at E3 -> all regs 0, BUSY=0 after that edge; then CLEAR with WRITE r2=8'h09 on E0 -> write accepted, r2 reads 0 after the sweep completes.
- REG_FILE_ZERO_REG_EN: write 8'hEE to r0 with OUT1ADDRESS=0 -> OUT1=8'h00 and WR_REJECT=0; with the macro undefined -> OUT1=8'hEE.
